// File: rtl/psc_frame_scheduler.sv
// Byte-level frame scheduler for the PSC trigger link: arbitrates one trigger source
// against NUM_REQ command requesters and sequences SOF/TYPE/payload/CRC/EOF bytes.
module psc_frame_scheduler #(
  parameter int          NUM_REQ     = 2,
  parameter int          PAYLOAD_LEN = 4,
  parameter int          IDLE_GAP    = 1,
  parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
  parameter logic [7:0]  SOF_BYTE    = 8'h3C,
  parameter logic [7:0]  EOF_BYTE    = 8'hFD,
  parameter logic [7:0]  TRIG_TYPE   = 8'h01,
  localparam int         SEL_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int         IDX_W       = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger_pulse,
  input  logic [NUM_REQ-1:0] req,
  input  logic [7:0]         payload_data,
  output logic [SEL_W-1:0]   payload_sel,
  output logic [IDX_W-1:0]   payload_idx,
  output logic               payload_rd,
  output logic [NUM_REQ-1:0] ack,
  output logic [7:0]         tx_byte,
  output logic               is_control_byte,
  output logic               is_crc_byte,
  output logic               crc_reset,
  output logic               busy,
  output logic               trigger_drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_TYPE, S_PAYLOAD, S_CRC, S_EOF, S_GAP
  } state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel, sel_n, rr_ptr, rr_n, grant;
  logic               is_trig, is_trig_n;
  logic               trig_pending, pend_n, drop_n, trig_grant;
  logic [IDX_W-1:0]   cnt, cnt_n, pidx_n;
  logic [3:0]         gap_cnt, gap_n;
  logic               gap_done, found;
  logic [NUM_REQ-1:0] onehot, ack_n;
  logic [7:0]         tx_n;
  logic               ctrl_n, crcf_n, crcrst_n, rd_n, busy_n;
  int                 j;

  assign payload_sel = sel;
  assign gap_done    = (gap_cnt == 4'(IDLE_GAP - 1));

  // Next-state, pending-trigger bookkeeping and output decode of the next state, so
  // every output register always describes the byte the state register names.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    rr_n       = rr_ptr;
    is_trig_n  = is_trig;
    cnt_n      = cnt;
    gap_n      = gap_cnt;
    trig_grant = 1'b0;
    found      = 1'b0;
    grant      = '0;
    onehot     = '0;
    j          = 0;

    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      onehot = NUM_REQ'(1) << j;
      if (!found && ((req & onehot) != '0)) begin
        found = 1'b1;
        grant = SEL_W'(j);
      end
    end

    case (state)
      // The last GAP byte arbitrates like IDLE so back-to-back frames keep exactly IDLE_GAP idles.
      S_IDLE, S_GAP: begin
        if (state == S_GAP && !gap_done) begin
          gap_n = gap_cnt + 4'd1;
        end else if (trig_pending || trigger_pulse) begin
          state_n    = S_SOF;
          is_trig_n  = 1'b1;
          trig_grant = 1'b1;
        end else if (found) begin
          state_n   = S_SOF;
          is_trig_n = 1'b0;
          sel_n     = grant;
          rr_n      = (grant == SEL_W'(NUM_REQ - 1)) ? '0 : grant + SEL_W'(1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SOF:  state_n = S_TYPE;
      S_TYPE: begin
        cnt_n   = '0;
        state_n = is_trig ? S_CRC : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (cnt == IDX_W'(PAYLOAD_LEN - 1)) state_n = S_CRC;
        else                                cnt_n   = cnt + IDX_W'(1);
      end
      S_CRC:  state_n = S_EOF;
      S_EOF: begin
        state_n = S_GAP;
        gap_n   = '0;
      end
      default: state_n = S_IDLE;
    endcase

    // A pulse coinciding with the grant of an already pending trigger re-arms the flag.
    drop_n = 1'b0;
    pend_n = trig_pending;
    if (trig_grant) begin
      pend_n = trig_pending & trigger_pulse;
    end else if (trigger_pulse) begin
      drop_n = trig_pending;
      pend_n = 1'b1;
    end

    tx_n     = IDLE_BYTE;
    ctrl_n   = 1'b1;
    crcf_n   = 1'b0;
    crcrst_n = 1'b0;
    rd_n     = 1'b0;
    pidx_n   = '0;
    ack_n    = '0;
    busy_n   = 1'b1;
    case (state_n)
      S_SOF: begin
        tx_n     = SOF_BYTE;
        crcrst_n = 1'b1;
      end
      S_TYPE: begin
        tx_n   = is_trig_n ? TRIG_TYPE : 8'h10 + 8'(sel_n);
        ctrl_n = 1'b0;
        rd_n   = !is_trig_n;
      end
      S_PAYLOAD: begin
        tx_n   = payload_data;
        ctrl_n = 1'b0;
        if (cnt_n != IDX_W'(PAYLOAD_LEN - 1)) begin
          rd_n   = 1'b1;
          pidx_n = cnt_n + IDX_W'(1);
        end
      end
      S_CRC: begin
        tx_n   = 8'h00;
        ctrl_n = 1'b0;
        crcf_n = 1'b1;
      end
      S_EOF: begin
        tx_n = EOF_BYTE;
        for (int i = 0; i < NUM_REQ; i++)
          ack_n[i] = !is_trig_n && (sel_n == SEL_W'(i));
      end
      default: busy_n = 1'b0;
    endcase
  end

  // State, arbitration bookkeeping and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      sel             <= '0;
      rr_ptr          <= '0;
      is_trig         <= 1'b0;
      trig_pending    <= 1'b0;
      cnt             <= '0;
      gap_cnt         <= '0;
      tx_byte         <= IDLE_BYTE;
      is_control_byte <= 1'b1;
      is_crc_byte     <= 1'b0;
      crc_reset       <= 1'b0;
      payload_rd      <= 1'b0;
      payload_idx     <= '0;
      ack             <= '0;
      busy            <= 1'b0;
      trigger_drop    <= 1'b0;
    end else begin
      state           <= state_n;
      sel             <= sel_n;
      rr_ptr          <= rr_n;
      is_trig         <= is_trig_n;
      trig_pending    <= pend_n;
      cnt             <= cnt_n;
      gap_cnt         <= gap_n;
      tx_byte         <= tx_n;
      is_control_byte <= ctrl_n;
      is_crc_byte     <= crcf_n;
      crc_reset       <= crcrst_n;
      payload_rd      <= rd_n;
      payload_idx     <= pidx_n;
      ack             <= ack_n;
      busy            <= busy_n;
      trigger_drop    <= drop_n;
    end
  end

endmodule
